cpu_regfile_gen: RTL and testbench

Parametrised 6502-family register file: accumulator, stack pointer, N index registers, program counter with byte-staged and relative loads, and processor status register P. It sits between the control unit and the ALU/bus interface of the CPU core. It adds defined priorities for simultaneous events, page-cross and stack-wrap reporting, and an optional interrupt shadow bank.

---
 rtl/cpu_regs_pkg.sv | 33 +++
 rtl/cpu_status_reg.sv | 70 +++++++
 rtl/cpu_regfile_gen.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_regfile_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared types and constants for the 6502-family register file.
package cpu_regs_pkg;

    // Program counter operations; encodings 6 and 7 behave as HOLD.
    typedef enum logic [2:0] {
        PC_HOLD    = 3'd0,
        PC_INC     = 3'd1,
        PC_LOAD    = 3'd2,
        PC_LOAD_LO = 3'd3,
        PC_LOAD_HI = 3'd4,
        PC_REL     = 3'd5
    } pc_op_e;

    // Stack pointer operations; encoding 3 behaves as NONE.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_PUSH = 2'd1,
        SP_POP  = 2'd2
    } sp_op_e;

    // Status register bit positions (NV1BDIZC).
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h24;

endpackage

// File: rtl/cpu_status_reg.sv
// Processor status register P: flag update priority, fixed bits 5/4,
// and whole-register load from the interrupt shadow.
module cpu_status_reg
    import cpu_regs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              nz_upd,
    input  logic              c_we,
    input  logic              c_in,
    input  logic              v_we,
    input  logic              v_in,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic              d_set,
    input  logic              d_clr,
    input  logic              p_we,
    input  logic              i_force,
    input  logic              restore,
    input  logic [7:0]        restore_p,
    output logic [7:0]        p
);

    logic [7:0] data_byte;
    logic [7:0] p_next;

    // Low byte of data_in, zero-extended when DATA_W is narrower than 8.
    always_comb begin
        data_byte = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < DATA_W) data_byte[i] = data_in[i];
        end
    end

    // Priority: restore > p_we > individual flags; interrupt entry forces I.
    always_comb begin
        p_next = p;
        if (restore) begin
            p_next = restore_p;
        end else begin
            if (p_we) begin
                p_next = data_byte;
            end else begin
                if (nz_upd) begin
                    p_next[P_N] = data_in[DATA_W-1];
                    p_next[P_Z] = (data_in == '0);
                end
                if (c_we) p_next[P_C] = c_in;
                if (v_we) p_next[P_V] = v_in;
                if (i_set)      p_next[P_I] = 1'b1;
                else if (i_clr) p_next[P_I] = 1'b0;
                if (d_set)      p_next[P_D] = 1'b1;
                else if (d_clr) p_next[P_D] = 1'b0;
            end
            if (i_force) p_next[P_I] = 1'b1;
        end
        p_next[P_U] = 1'b1;
        p_next[P_B] = 1'b0;
    end

    // P register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p <= P_RESET;
        else        p <= p_next;
    end

endmodule

// File: rtl/cpu_regfile_gen.sv
// 6502-family register file: A, SP, index registers, PC with byte-staged
// and relative loads, and P. Define CPU_REGFILE_SHADOW_EN to build the
// interrupt shadow bank; otherwise irq_save/irq_restore are ignored.
module cpu_regfile_gen
    import cpu_regs_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 PC_W     = 16,
    parameter int                 NUM_IDX  = 2,
    parameter logic [PC_W-1:0]    RESET_PC = 16'hC000,
    parameter logic [DATA_W-1:0]  RESET_SP = 8'hFF,
    localparam int                SEL_W    = $clog2(NUM_IDX + 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_we,
    input  logic [SEL_W-1:0]          reg_sel,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [2:0]                pc_op,
    input  logic [PC_W-1:0]           pc_in,
    input  logic [1:0]                sp_op,
    input  logic                      nz_upd,
    input  logic                      c_we,
    input  logic                      c_in,
    input  logic                      v_we,
    input  logic                      v_in,
    input  logic                      i_set,
    input  logic                      i_clr,
    input  logic                      d_set,
    input  logic                      d_clr,
    input  logic                      p_we,
    input  logic                      irq_save,
    input  logic                      irq_restore,
    output logic [DATA_W-1:0]         reg_a,
    output logic [DATA_W-1:0]         reg_sp,
    output logic [NUM_IDX*DATA_W-1:0] reg_idx,
    output logic [PC_W-1:0]           reg_pc,
    output logic [7:0]                reg_p,
    output logic                      page_cross,
    output logic                      sp_wrap,
    output logic                      shadow_valid
);

    logic [NUM_IDX-1:0][DATA_W-1:0] idx_q;
    logic [7:0]                     lo_q;
    logic [7:0]                     lo_next;
    logic [7:0]                     data_lo;
    logic [PC_W-9:0]                data_hi;
    logic [PC_W-1:0]                rel_ext;
    logic [PC_W-1:0]                pc_next;
    logic                           page_cross_next;
    logic [DATA_W-1:0]              sp_next;
    logic                           sp_wrap_next;
    logic                           sp_write;
    logic                           restore_fire;
    logic                           save_fire;
    logic [PC_W-1:0]                shadow_pc_out;
    logic [7:0]                     shadow_p_out;

    assign sp_write = reg_we && (reg_sel == SEL_W'(1));
    assign rel_ext  = {{(PC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
    assign reg_idx  = idx_q;

`ifdef CPU_REGFILE_SHADOW_EN
    logic [PC_W-1:0] shadow_pc;
    logic [7:0]      shadow_p;
    logic            shadow_q;

    // A restore only fires with a valid snapshot, and then wins over a save.
    assign restore_fire  = irq_restore & shadow_q;
    assign save_fire     = irq_save & ~restore_fire;
    assign shadow_valid  = shadow_q;
    assign shadow_pc_out = shadow_pc;
    assign shadow_p_out  = shadow_p;

    // Snapshot PC/P on interrupt entry; consume on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_pc <= '0;
            shadow_p  <= P_RESET;
            shadow_q  <= 1'b0;
        end else if (restore_fire) begin
            shadow_q  <= 1'b0;
        end else if (save_fire) begin
            shadow_pc <= reg_pc;
            shadow_p  <= reg_p;
            shadow_q  <= 1'b1;
        end
    end
`else
    logic unused_shadow_ctrl;

    assign unused_shadow_ctrl = irq_save ^ irq_restore;
    assign restore_fire       = 1'b0;
    assign save_fire          = 1'b0;
    assign shadow_valid       = 1'b0;
    assign shadow_pc_out      = '0;
    assign shadow_p_out       = P_RESET;
`endif

    // Byte views of data_in for the staged PC load (zero-extend/truncate).
    always_comb begin
        data_lo = '0;
        data_hi = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < DATA_W) data_lo[i] = data_in[i];
        end
        for (int i = 0; i < PC_W - 8; i++) begin
            if (i < DATA_W) data_hi[i] = data_in[i];
        end
    end

    // Next PC and lo-stage; a shadow restore overrides every pc_op.
    always_comb begin
        pc_next         = reg_pc;
        lo_next         = lo_q;
        page_cross_next = 1'b0;
        if (restore_fire) begin
            pc_next = shadow_pc_out;
        end else begin
            case (pc_op)
                PC_INC:     pc_next = reg_pc + PC_W'(1);
                PC_LOAD:    pc_next = pc_in;
                PC_LOAD_LO: lo_next = data_lo;
                PC_LOAD_HI: pc_next = {data_hi, lo_q};
                PC_REL: begin
                    pc_next         = reg_pc + rel_ext;
                    page_cross_next = (pc_next[PC_W-1:8] != reg_pc[PC_W-1:8]);
                end
                default: ;
            endcase
        end
    end

    // Next SP; a direct register write beats push/pop and reports no wrap.
    always_comb begin
        sp_next      = reg_sp;
        sp_wrap_next = 1'b0;
        if (sp_write) begin
            sp_next = data_in;
        end else begin
            case (sp_op)
                SP_PUSH: begin
                    sp_next      = reg_sp - DATA_W'(1);
                    sp_wrap_next = (reg_sp == '0);
                end
                SP_POP: begin
                    sp_next      = reg_sp + DATA_W'(1);
                    sp_wrap_next = (reg_sp == '1);
                end
                default: ;
            endcase
        end
    end

    // A, SP, PC, lo-stage and the one-cycle event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a      <= '0;
            reg_sp     <= RESET_SP;
            reg_pc     <= RESET_PC;
            lo_q       <= '0;
            page_cross <= 1'b0;
            sp_wrap    <= 1'b0;
        end else begin
            if (reg_we && (reg_sel == '0)) reg_a <= data_in;
            reg_sp     <= sp_next;
            reg_pc     <= pc_next;
            lo_q       <= lo_next;
            page_cross <= page_cross_next;
            sp_wrap    <= sp_wrap_next;
        end
    end

    // Index registers; selects beyond the last index register are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            for (int k = 0; k < NUM_IDX; k++) begin
                if (reg_we && (reg_sel == SEL_W'(k + 2))) idx_q[k] <= data_in;
            end
        end
    end

    cpu_status_reg #(
        .DATA_W (DATA_W)
    ) u_status (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .nz_upd    (nz_upd),
        .c_we      (c_we),
        .c_in      (c_in),
        .v_we      (v_we),
        .v_in      (v_in),
        .i_set     (i_set),
        .i_clr     (i_clr),
        .d_set     (d_set),
        .d_clr     (d_clr),
        .p_we      (p_we),
        .i_force   (save_fire),
        .restore   (restore_fire),
        .restore_p (shadow_p_out),
        .p         (reg_p)
    );

endmodule

// File: tb/tb_cpu_regfile_gen.sv
// Self-checking bench for cpu_regfile_gen (default parameters).
module tb_cpu_regfile_gen;

`ifdef CPU_REGFILE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk, rst_n;
    logic        reg_we;
    logic [1:0]  reg_sel;
    logic [7:0]  data_in;
    logic [2:0]  pc_op;
    logic [15:0] pc_in;
    logic [1:0]  sp_op;
    logic        nz_upd, c_we, c_in, v_we, v_in;
    logic        i_set, i_clr, d_set, d_clr, p_we;
    logic        irq_save, irq_restore;
    logic [7:0]  reg_a, reg_sp, reg_p;
    logic [15:0] reg_idx, reg_pc;
    logic        page_cross, sp_wrap, shadow_valid;

    int n_checks = 0;
    int n_errors = 0;

    cpu_regfile_gen dut (
        .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_sel(reg_sel),
        .data_in(data_in), .pc_op(pc_op), .pc_in(pc_in), .sp_op(sp_op),
        .nz_upd(nz_upd), .c_we(c_we), .c_in(c_in), .v_we(v_we), .v_in(v_in),
        .i_set(i_set), .i_clr(i_clr), .d_set(d_set), .d_clr(d_clr),
        .p_we(p_we), .irq_save(irq_save), .irq_restore(irq_restore),
        .reg_a(reg_a), .reg_sp(reg_sp), .reg_idx(reg_idx), .reg_pc(reg_pc),
        .reg_p(reg_p), .page_cross(page_cross), .sp_wrap(sp_wrap),
        .shadow_valid(shadow_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_a, m_sp, m_pc, m_p, m_lo, m_pcx, m_spw, m_shv, m_spc, m_sp_p;
    int m_idx [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_idx[0] <= 0; m_idx[1] <= 0; m_sp <= 'hFF; m_pc <= 'hC000;
            m_p <= 'h24; m_lo <= 0; m_pcx <= 0; m_spw <= 0; m_shv <= 0;
            m_spc <= 0; m_sp_p <= 'h24;
        end else begin : step
            int pc_n, p_n, sp_n, lo_n, rel, wrap, pcx;
            bit rest, save;
            rest = SHADOW && irq_restore && (m_shv != 0);
            save = SHADOW && irq_save && !rest;
            if (reg_we && reg_sel == 0) m_a <= data_in;
            if (reg_we && reg_sel >= 2) m_idx[reg_sel - 2] <= data_in;
            sp_n = m_sp; wrap = 0;
            if (reg_we && reg_sel == 1) sp_n = data_in;
            else if (sp_op == 1) begin sp_n = (m_sp + 255) % 256; wrap = (m_sp == 0); end
            else if (sp_op == 2) begin sp_n = (m_sp + 1) % 256; wrap = (m_sp == 255); end
            pc_n = m_pc; lo_n = m_lo; pcx = 0;
            if (rest) pc_n = m_spc;
            else case (pc_op)
                1: pc_n = (m_pc + 1) % 65536;
                2: pc_n = pc_in;
                3: lo_n = data_in;
                4: pc_n = data_in * 256 + m_lo;
                5: begin
                    rel  = (data_in < 128) ? int'(data_in) : int'(data_in) - 256;
                    pc_n = (m_pc + rel + 65536) % 65536;
                    pcx  = ((pc_n / 256) != (m_pc / 256));
                end
                default: ;
            endcase
            if (rest) p_n = m_sp_p;
            else if (p_we) p_n = data_in;
            else begin
                p_n = m_p;
                if (nz_upd) begin
                    p_n = data_in[7] ? (p_n | 'h80) : (p_n & ~'h80);
                    p_n = (data_in == 0) ? (p_n | 'h02) : (p_n & ~'h02);
                end
                if (c_we) p_n = c_in ? (p_n | 'h01) : (p_n & ~'h01);
                if (v_we) p_n = v_in ? (p_n | 'h40) : (p_n & ~'h40);
                if (i_set) p_n = p_n | 'h04; else if (i_clr) p_n = p_n & ~'h04;
                if (d_set) p_n = p_n | 'h08; else if (d_clr) p_n = p_n & ~'h08;
            end
            if (save && !rest) p_n = p_n | 'h04;
            p_n = ((p_n | 'h20) & ~'h10) & 'hFF;
            if (rest) m_shv <= 0;
            else if (save) begin m_shv <= 1; m_spc <= m_pc; m_sp_p <= m_p; end
            m_sp <= sp_n; m_pc <= pc_n; m_lo <= lo_n; m_p <= p_n;
            m_pcx <= pcx; m_spw <= wrap;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_a", reg_a, m_a);
            chk("model_sp", reg_sp, m_sp);
            chk("model_idx", reg_idx, (m_idx[1] << 8) | m_idx[0]);
            chk("model_pc", reg_pc, m_pc);
            chk("model_p", reg_p, m_p);
            chk("model_page_cross", page_cross, m_pcx);
            chk("model_sp_wrap", sp_wrap, m_spw);
            chk("model_shadow_valid", shadow_valid, m_shv);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        reg_we = 0; reg_sel = 0; data_in = 0; pc_op = 0; pc_in = 0; sp_op = 0;
        nz_upd = 0; c_we = 0; c_in = 0; v_we = 0; v_in = 0;
        i_set = 0; i_clr = 0; d_set = 0; d_clr = 0; p_we = 0;
        irq_save = 0; irq_restore = 0;
    endtask

    task automatic go();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a", reg_a, 8'h00);
        chk("rst_idx", reg_idx, 16'h0000);
        chk("rst_sp", reg_sp, 8'hFF);
        chk("rst_pc", reg_pc, 16'hC000);
        chk("rst_p", reg_p, 8'h24);
        chk("rst_pulses", {page_cross, sp_wrap, shadow_valid}, 3'b000);
        rst_n = 1'b1;
        go();

        // Staged PC load with an unrelated op in between.
        pc_op = 3; data_in = 8'h34; go();
        chk("load_lo_hold", reg_pc, 16'hC000);
        pc_op = 1; go();
        chk("inc", reg_pc, 16'hC001);
        pc_op = 4; data_in = 8'h12; go();
        chk("load_hi", reg_pc, 16'h1234);

        // Relative branches.
        pc_op = 2; pc_in = 16'hC0F0; go();
        pc_op = 5; data_in = 8'h20; go();
        chk("rel_fwd_pc", reg_pc, 16'hC110);
        chk("rel_fwd_cross", page_cross, 1'b1);
        go();
        chk("rel_cross_pulse", page_cross, 1'b0);
        pc_op = 2; pc_in = 16'hC010; go();
        pc_op = 5; data_in = 8'hF0; go();
        chk("rel_back_pc", reg_pc, 16'hC000);
        chk("rel_back_cross", page_cross, 1'b0);
        pc_op = 2; pc_in = 16'hFFFF; go();
        pc_op = 1; go();
        chk("inc_wrap", reg_pc, 16'h0000);

        // Stack pointer wrap and write priority.
        reg_we = 1; reg_sel = 1; data_in = 8'h00; go();
        sp_op = 1; go();
        chk("push_wrap_sp", reg_sp, 8'hFF);
        chk("push_wrap_flag", sp_wrap, 1'b1);
        go();
        chk("wrap_pulse", sp_wrap, 1'b0);
        sp_op = 2; go();
        chk("pop_wrap_sp", {sp_wrap, reg_sp}, 9'h100);
        reg_we = 1; reg_sel = 1; data_in = 8'h80; sp_op = 2; go();
        chk("sp_write_prio", {sp_wrap, reg_sp}, 9'h080);

        // Index registers.
        reg_we = 1; reg_sel = 2; data_in = 8'h5A; go();
        reg_we = 1; reg_sel = 3; data_in = 8'hA5; go();
        chk("idx_xy", reg_idx, 16'hA55A);

        // Flags.
        reg_we = 1; reg_sel = 0; data_in = 8'h80; nz_upd = 1; go();
        chk("nz_a", reg_a, 8'h80);
        chk("nz_p", reg_p, 8'hA4);
        p_we = 1; data_in = 8'hFF; c_we = 1; c_in = 0; go();
        chk("p_we_prio", reg_p, 8'hEF);
        nz_upd = 1; data_in = 8'h00; go();
        chk("nz_zero", reg_p, 8'h6F);
        c_we = 1; v_we = 1; i_set = 1; i_clr = 1; d_set = 1; d_clr = 1; go();
        chk("set_beats_clr", reg_p, 8'h2E);

        // Interrupt shadow.
        pc_op = 2; pc_in = 16'h1234; p_we = 1; data_in = 8'h24; go();
        irq_save = 1; go();
        chk("save_valid", shadow_valid, SHADOW);
        chk("save_p", reg_p, 8'h24);
        pc_op = 2; pc_in = 16'hFFFE; go();
        i_clr = 1; go();
        chk("pre_restore_p", reg_p, 8'h20);
        irq_restore = 1; pc_op = 1; go();
        chk("restore_pc", reg_pc, SHADOW ? 16'h1234 : 16'hFFFF);
        chk("restore_p", reg_p, SHADOW ? 8'h24 : 8'h20);
        chk("restore_valid", shadow_valid, 1'b0);
        irq_restore = 1; pc_op = 1; go();
        chk("restore_ignored", reg_pc, SHADOW ? 16'h1235 : 16'h0000);
        irq_save = 1; go();
        irq_save = 1; irq_restore = 1; go();
        chk("restore_beats_save", shadow_valid, 1'b0);

        // Asynchronous reset mid-sequence clears lo-stage and shadow.
        pc_op = 3; data_in = 8'h77; go();
        irq_save = 1; go();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        pc_op = 4; data_in = 8'h12; go();
        chk("rst_lo_cleared", reg_pc, 16'h1200);
        chk("rst_shadow_cleared", shadow_valid, 1'b0);
        chk("rst_sp_again", reg_sp, 8'hFF);
        go();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
